// File: rtl/param_commit_ctrl_if.sv
// Host write port and commit bus for param_commit_ctrl.
// Readback signals exist only with PARAM_COMMIT_READBACK_EN.
interface param_commit_ctrl_if #(
  parameter int NUM_PARAMS = 8,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3
);
  logic                  wr_req;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_ready;
  logic                  sample_tick;
  logic [NUM_PARAMS-1:0] commit_valid;
  logic [DATA_W-1:0]     commit_data;
  logic                  busy;
  logic                  overrun;
`ifdef PARAM_COMMIT_READBACK_EN
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, sample_tick, rd_addr,
    input  wr_ready, commit_valid, commit_data, busy, overrun, rd_data
  );
  modport slave (
    input  wr_req, wr_addr, wr_data, sample_tick, rd_addr,
    output wr_ready, commit_valid, commit_data, busy, overrun, rd_data
  );
`else
  modport master (
    output wr_req, wr_addr, wr_data, sample_tick,
    input  wr_ready, commit_valid, commit_data, busy, overrun
  );
  modport slave (
    input  wr_req, wr_addr, wr_data, sample_tick,
    output wr_ready, commit_valid, commit_data, busy, overrun
  );
`endif
endinterface

// File: rtl/param_commit_ctrl.sv
// Shadow parameter bank, committed one word per cycle on sample_tick.
// Optional readback port: define PARAM_COMMIT_READBACK_EN.
module param_commit_ctrl #(
  parameter int NUM_PARAMS = 8,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3
) (
  input logic clk,
  input logic rst,
  param_commit_ctrl_if.slave bus
);

  typedef enum logic {IDLE, COMMIT} state_t;

  localparam logic [ADDR_W:0] NUM_P = (ADDR_W+1)'(NUM_PARAMS);

  state_t                state, state_nx;
  logic [DATA_W-1:0]     shadow [NUM_PARAMS];
  logic [NUM_PARAMS-1:0] dirty;
  logic [NUM_PARAMS-1:0] pick;
  logic [NUM_PARAMS-1:0] wr_mask;
  logic [ADDR_W-1:0]     pick_idx;
  logic                  do_commit;
  logic                  wr_hit;

  assign bus.wr_ready = (state == IDLE) && !bus.sample_tick;
  assign bus.busy     = (state == COMMIT);
  assign wr_hit = bus.wr_req && bus.wr_ready
               && ({1'b0, bus.wr_addr} < NUM_P);

  // Lowest dirty index and the write-enable mask.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    wr_mask  = '0;
    for (int i = NUM_PARAMS - 1; i >= 0; i--) begin
      if (dirty[i]) begin
        pick     = '0;
        pick[i]  = 1'b1;
        pick_idx = i[ADDR_W-1:0];
      end
    end
    if (wr_hit) wr_mask[bus.wr_addr] = 1'b1;
  end

  // Next state: scan while dirty words remain after this commit.
  always_comb begin
    state_nx  = state;
    do_commit = 1'b0;
    unique case (state)
      IDLE:    do_commit = bus.sample_tick && (|dirty);
      COMMIT:  do_commit = 1'b1;
      default: do_commit = 1'b0;
    endcase
    if (do_commit)
      state_nx = (|(dirty & ~pick)) ? COMMIT : IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Shadow bank, dirty bits, commit outputs and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PARAMS; i++) shadow[i] <= '0;
      dirty            <= '0;
      bus.commit_valid <= '0;
      bus.commit_data  <= '0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.commit_valid <= '0;
      if (wr_hit) shadow[bus.wr_addr] <= bus.wr_data;
      dirty <= (dirty & ~(do_commit ? pick : '0)) | wr_mask;
      if (do_commit) begin
        bus.commit_valid <= pick;
        bus.commit_data  <= shadow[pick_idx];
      end
      if ((state == COMMIT) && bus.sample_tick)
        bus.overrun <= 1'b1;
    end
  end

`ifdef PARAM_COMMIT_READBACK_EN
  // Registered readback of the shadow bank.
  always_ff @(posedge clk) begin
    if (rst)
      bus.rd_data <= '0;
    else if ({1'b0, bus.rd_addr} < NUM_P)
      bus.rd_data <= shadow[bus.rd_addr];
    else
      bus.rd_data <= '0;
  end
`endif

endmodule
